// File: rtl/apb_completer_mem_if.sv
// APB4 bus bundle between a requester (master) and a completer (slave).
// Pure wiring: no latency, no storage.
// Flow control is carried by pready; the completer owns it.
interface apb_completer_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [STRB_WIDTH-1:0] pstrb;
    logic [2:0]            pprot;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_completer_mem.sv
// APB4 completer: word memory with byte strobes, wait states and PSLVERR; APB_PROT_CHECK_EN adds PPROT region checks.
// Latency: completes on access cycle WAIT_STATES+1; request captured at setup, read data registered at setup.
// Backpressure: holds pready low for WAIT_STATES cycles; psel dropped mid-transfer yields a one-cycle error (ABORT).
module apb_completer_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_STATES = 1
) (
    input logic               pclk,
    input logic               reset,
    apb_completer_mem_if.slave bus
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    // Bits between the word index and the three protection-region bits.
    localparam logic [ADDR_WIDTH-1:0] RANGE_MASK =
        ((ONE << (ADDR_WIDTH - 3)) - ONE) & ~((ONE << (2 + IDX_W)) - ONE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ABORT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_write;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_strb;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_setup;
    logic                  w_access;
    logic                  w_cnt_zero;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_misalign;
    logic                  w_range_err;
    logic                  w_prot_err;
    logic                  w_err;
    logic                  w_done;
    logic                  w_pready;
    logic                  w_pslverr;
    logic [DATA_WIDTH-1:0] w_prdata;

    assign w_setup     = bus.psel & ~bus.penable;
    assign w_access    = bus.psel & bus.penable;
    assign w_cnt_zero  = (r_cnt == 4'd0);
    assign w_idx       = bus.paddr[2 +: IDX_W];
    assign w_misalign  = |bus.paddr[1:0];
    assign w_range_err = |(bus.paddr & RANGE_MASK);

`ifdef APB_PROT_CHECK_EN
    assign w_prot_err = (bus.paddr[ADDR_WIDTH-1] & ~bus.pprot[0])
                      | (bus.paddr[ADDR_WIDTH-2] & ~bus.pprot[1])
                      | (bus.paddr[ADDR_WIDTH-3] & ~bus.pprot[2]);
`else
    logic w_unused_prot;
    assign w_unused_prot = ^bus.pprot;
    assign w_prot_err    = 1'b0;
`endif

    assign w_err = w_misalign | w_range_err | w_prot_err;

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pready     = 1'b0;
        w_pslverr    = 1'b0;
        w_prdata     = '0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_setup) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_pready  = w_cnt_zero;
                w_pslverr = w_cnt_zero & r_err;
                w_prdata  = r_prdata;
                if (!bus.psel) begin
                    w_next_state = ST_ABORT;
                end else if (w_access && w_cnt_zero) begin
                    w_next_state = ST_IDLE;
                    w_done       = 1'b1;
                end
            end
            ST_ABORT: begin
                w_pready     = 1'b1;
                w_pslverr    = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign bus.pready  = w_pready;
    assign bus.pslverr = w_pslverr;
    assign bus.prdata  = w_prdata;

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_cnt    <= 4'd0;
            r_idx    <= '0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_wdata  <= '0;
            r_strb   <= '0;
            r_prdata <= '0;
        end else if (r_state == ST_IDLE && w_setup) begin
            r_cnt    <= 4'(WAIT_STATES);
            r_idx    <= w_idx;
            r_write  <= bus.pwrite;
            r_err    <= w_err;
            r_wdata  <= bus.pwdata;
            r_strb   <= bus.pstrb;
            r_prdata <= (!bus.pwrite && !w_err) ? r_mem[w_idx] : '0;
        end else if (r_state == ST_ACCESS && w_access && !w_cnt_zero) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Memory is deliberately not reset; only a clean completed write touches it.
    always_ff @(posedge pclk) begin
        if (w_done && r_write && !r_err && !reset) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (r_strb[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end
endmodule
